fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that sits on the consuming side of the core control signals (`jump_addr`, `jump`, `stall_n`, `flush`). It generates sequential PCs, issues requests on a valid/ready instruction-memory port, and tracks in-flight requests. In-order responses land in a small instruction buffer. It delivers `{pc, inst}` pairs to decode, honours stall, and redirects on jump/flush while discarding stale in-flight responses.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default `4`: instruction buffer entries; power of two, ≥2. Also the cap on outstanding requests plus buffered entries.

- `clk`  in  1  core clock.
- `rst_sync`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `jump_addr`  in  32  redirect target, valid when `jump`=1.
- `jump`  in  1  redirect request.
- `stall_n`  in  1  0: decode stalled, 1: decode accepts.
- `flush`  in  1  discard buffered and in-flight instructions.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  fetch address, word aligned.
- `imem_rsp_valid`  in  1  response valid; in order, always accepted, never before the cycle after its request handshake.
- `imem_rsp_data`  in  32  instruction word.
- `if_valid`  out  1  `if_pc`/`if_inst` hold a valid instruction.
- `if_pc`  out  32  PC of the delivered instruction.
- `if_inst`  out  32  delivered instruction.

## Operation
- State:
  - `pc`: next request address.
  - `rsp_pc`: PC of the next non-dropped response.
  - `out_cnt`: in-flight requests, 0..DEPTH.
  - `drop_cnt`: in-flight responses to discard.
  - Buffer: circular, DEPTH entries of `{pc, inst}`, with `cnt`.
- Request: `imem_req_valid` = 1 when reset is not asserted, `flush`=0, `jump`=0, and `out_cnt + cnt < DEPTH` (registered values). `imem_req_addr` = `pc`.
- On a valid&&ready handshake: `pc` += 4 (wraps modulo 2^32), `out_cnt`++.
- Response:
  - Every `imem_rsp_valid` decrements `out_cnt`.
  - If `drop_cnt` > 0: the data is discarded and `drop_cnt`--.
  - Otherwise `{rsp_pc, data}` is pushed and `rsp_pc` += 4.
  - The credit rule guarantees a push never meets a full buffer.
- Delivery: `if_valid` = (`cnt` ≠ 0) && !`flush` && !`jump`. `if_pc`/`if_inst` = head entry. Pop when `if_valid` && `stall_n`. Push and pop in the same cycle are both performed.
- When buffer is empty: `if_pc` = 0, `if_inst` = `32'h0000_0013` (NOP).
- Redirect (`jump`=1; `flush` is implied whether or not it is asserted):
  - Next cycle: `pc` = `rsp_pc` = `{jump_addr[31:2],2'b00}`.
  - Buffer emptied.
  - `drop_cnt` = `out_cnt` − `imem_rsp_valid` (same-cycle response is dropped).
  - No request is issued in the redirect cycle.
- `flush`=1 with `jump`=0: same as a redirect, with target = head `pc` if `cnt` ≠ 0, else `rsp_pc`.
- `stall_n`=0 holds the head. Requests continue until credits are exhausted.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_inst`=`32'h0000_0013`.
- Reset values of internal state: `out_cnt`=`drop_cnt`=`cnt`=0.
- First request: `imem_req_valid`=1 in the first cycle after `rst_sync` deasserts.
- Latency: request handshake at cycle N, response at N+k (k≥1), `if_valid` at N+k+1.
- Redirect at cycle R: the first new request is at R+1 with address `jump_addr`. Its instruction is visible no earlier than R+3.
- Reset mid-operation: all state is cleared in the same edge. Responses still arriving from the pre-reset bus are the memory's responsibility to suppress.
- Wrap-around: buffer pointers wrap modulo DEPTH, and `pc` wraps at 2^32. Neither case is treated as an error.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds output `flush_drop_cnt` [31:0]. It resets to 0, increments once per discarded response, and once per buffer entry cleared by a redirect (saturating at `32'hFFFF_FFFF`).
- `FETCH_PERF_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, `RESET_PC`=`32'h100`, ready=1, 1-cycle memory, `stall_n`=1 → requests `0x100, 0x104, 0x108…`. `if_valid` at 3rd cycle after reset with `if_pc`=`0x100`.
- `stall_n`=0 for 10 cycles, DEPTH=4 → at most 4 requests beyond the delivered head. `imem_req_valid` drops, no overflow, order is preserved on release.
- 2 requests outstanding, then `jump`=`flush`=1, `jump_addr`=`0x200` → both responses dropped, next request `0x200`, first delivered `if_pc`=`0x200`.
- Redirect in the same cycle as `imem_rsp_valid` → that response is discarded, and `drop_cnt` = `out_cnt`−1.
- `jump_addr`=`0x203` → fetch address `0x200`. With `FETCH_PERF_CNT_EN`, `flush_drop_cnt` equals the dropped plus cleared entries (e.g., 2 after the 3rd scenario).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response buffer and jump/flush redirect. Optional FETCH_PERF_CNT_EN adds flush_drop_cnt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic [31:0] jump_addr,
  input  logic        jump,
  input  logic        stall_n,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] flush_drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];

  logic        redirect, credit_ok, hs, drop, push, pop, has_head;
  logic [31:0] head_pc, target;

  assign redirect  = jump | flush;
  assign has_head  = (cnt_q != '0);
  assign head_pc   = buf_pc_q[rd_ptr_q];
  assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, cnt_q}) < (CW+1)'(DEPTH);

  assign imem_req_valid = rst_sync && !redirect && credit_ok;
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;

  assign drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign push = imem_rsp_valid && !drop && !redirect;

  assign if_valid = rst_sync && has_head && !redirect;
  assign if_pc    = has_head ? head_pc : 32'h0;
  assign if_inst  = has_head ? buf_inst_q[rd_ptr_q] : NOP;
  assign pop      = if_valid && stall_n;

  // A plain flush refetches from the oldest instruction not yet handed to decode.
  assign target = jump ? (jump_addr & ~32'h3) : (has_head ? head_pc : rsp_pc_q);

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      pc_d       = target;
      rsp_pc_d   = target;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still in flight (minus this cycle's response) is stale.
      out_cnt_d  = out_cnt_q - CW'(imem_rsp_valid);
      drop_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
    end else begin
      if (hs) pc_d = pc_q + 32'd4;
      out_cnt_d = out_cnt_q + CW'(hs) - CW'(imem_rsp_valid);
      if (drop) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_sync) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
      buf_inst_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d, perf_inc;
  logic [32:0] perf_sum;

  // Counts dropped responses plus buffered entries thrown away by a redirect.
  always_comb begin
    perf_inc = 32'(imem_rsp_valid && (redirect || drop_cnt_q != '0));
    if (redirect) perf_inc = perf_inc + 32'(cnt_q);
    perf_sum = {1'b0, perf_q} + {1'b0, perf_inc};
    perf_d   = perf_sum[32] ? 32'hFFFF_FFFF : perf_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_sync) perf_q <= '0;
    else           perf_q <= perf_d;
  end

  assign flush_drop_cnt = perf_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-randomised in-order memory model feeds the DUT,
// expected {pc, inst} pairs are queued at request handshake and popped at delivery.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_sync, jump, stall_n, flush;
  logic [31:0] jump_addr;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_drop_cnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_sync       (rst_sync),
    .jump_addr      (jump_addr),
    .jump           (jump),
    .stall_n        (stall_n),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .flush_drop_cnt (flush_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  pend_t       pq[$];
  ent_t        eq[$];
  logic [31:0] exp_pc;
  logic [31:0] perf_exp = 0;
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, last_due = -1, lat_lo = 1, lat_hi = 1;
  int          first_ifv = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + (a << 3) + 32'h0000_0013;
  endfunction

  function automatic int live_pending();
    int n = 0;
    foreach (pq[i]) if (!pq[i].stale) n++;
    return n;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then advance the model.
  task automatic step(input bit j, input bit f, input logic [31:0] ja, input bit st, input bit rdy);
    int          buffered, d;
    bit          rv, want_ifv, want_rv;
    logic [31:0] tgt;
    ent_t        e;
    pend_t       p;
    buffered = eq.size() - live_pending();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_cnt", flush_drop_cnt, perf_exp);
`endif
    jump = j; flush = f; jump_addr = ja; stall_n = st; imem_req_ready = rdy;
    rv = (pq.size() != 0) && (pq[0].due <= cyc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? memf(pq[0].addr) : $urandom;
    #1;
    want_ifv = (buffered != 0) && !j && !f;
    chk("if_valid", {31'b0, if_valid}, {31'b0, want_ifv});
    if (if_valid && first_ifv < 0) first_ifv = cyc;
    if (want_ifv && if_valid) begin
      chk("if_pc", if_pc, eq[0].pc);
      chk("if_inst", if_inst, eq[0].inst);
      if (st) void'(eq.pop_front());
    end else if (buffered == 0) begin
      chk("empty_pc", if_pc, 32'h0);
      chk("empty_inst", if_inst, NOP);
    end
    want_rv = !j && !f && (pq.size() + buffered < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, want_rv});
    if (imem_req_valid && rdy) begin
      chk("req_addr", imem_req_addr, exp_pc);
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      p.addr = exp_pc; p.due = d; p.stale = 1'b0;
      pq.push_back(p);
      e.pc = exp_pc; e.inst = memf(exp_pc);
      eq.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (j || f) begin
      tgt = j ? (ja & ~32'h3) : ((eq.size() != 0) ? eq[0].pc : exp_pc);
      perf_exp = perf_exp + buffered;
      eq.delete();
      foreach (pq[i]) pq[i].stale = 1'b1;
      exp_pc = tgt;
    end
    if (rv) begin
      if (pq[0].stale) perf_exp = perf_exp + 1;
      void'(pq.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int guard = 0;
    while ((pq.size() != 0 || eq.size() != 0) && guard < 60) begin
      step(0, 0, 32'h0, 1, 0);
      guard++;
    end
    chk("drain_done", pq.size() + eq.size(), 0);
  endtask

  initial begin
    int cyc0;
    rst_sync = 0; jump = 0; flush = 0; stall_n = 1; jump_addr = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, NOP);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf", flush_drop_cnt, 32'h0);
`endif
    exp_pc = RST_PC;
    rst_sync = 1;
    cyc0 = cyc;

    // Streaming with a 1-cycle memory.
    lat_lo = 1; lat_hi = 1;
    repeat (12) step(0, 0, 32'h0, 1, 1);
    chk("first_ifv_lat", first_ifv - cyc0, 2);

    // Long decode stall: credits must cap requests, order kept on release.
    lat_lo = 1; lat_hi = 2;
    repeat (10) step(0, 0, 32'h0, 0, 1);
    repeat (10) step(0, 0, 32'h0, 1, 1);
    drain();

    // Two requests in flight, jump lands together with the first response.
    lat_lo = 2; lat_hi = 2;
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    step(1, 0, 32'h0000_0203, 1, 0);
    repeat (3) step(0, 0, 32'h0, 1, 1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_after_jump", flush_drop_cnt, 32'd2);
`endif
    repeat (8) step(0, 0, 32'h0, 1, 1);

    // Flush alone with a full buffer refetches from the head.
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(0, 0, 32'h0, 0, 1);
    step(0, 1, 32'h0, 0, 1);
    repeat (12) step(0, 0, 32'h0, 1, 1);

    // PC wrap-around at 2^32.
    step(1, 1, 32'hFFFF_FFF9, 1, 1);
    repeat (12) step(0, 0, 32'h0, 1, 1);

    // Random mix of ready, stall, latency, jump and flush.
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(99, 0);
      step(r < 4, (r >= 4 && r < 8), $urandom, $urandom_range(3, 0) != 0,
           $urandom_range(3, 0) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
